// File: rtl/pipe_shifter.sv
// Pipelined barrel shifter (SRL/SLL/SRA/ROL), one amount bit per stage; result LVL-1 edges after accept.
// Backpressure: the whole pipe stalls when the output holds an unconsumed result (IN_READY = !OUT_VALID || OUT_READY).
module pipe_shifter #(
  parameter int WIDTH   = 32,
  parameter int S_WIDTH = 32
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [WIDTH-1:0]   IN_D,
  input  logic [S_WIDTH-1:0] IN_S,
  input  logic [1:0]         IN_MODE,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [WIDTH-1:0]   OUT_Y,
  output logic               OUT_ZERO
);

  localparam int LVL = $clog2(WIDTH);

  localparam logic [1:0] MODE_SRL = 2'b00;
  localparam logic [1:0] MODE_SLL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  logic adv;

  logic             stVld  [LVL];
  logic [WIDTH-1:0] stData [LVL];
  logic [1:0]       stMode [LVL];
  logic [LVL-1:0]   stAmt  [LVL];
  logic             stSign [LVL];
  logic             stOvf  [LVL];
  logic             stZero;

  logic             inVld   [LVL];
  logic [WIDTH-1:0] inData  [LVL];
  logic [1:0]       inMode  [LVL];
  logic [LVL-1:0]   inAmt   [LVL];
  logic             inSign  [LVL];
  logic             inOvf   [LVL];
  logic [WIDTH-1:0] nxtData [LVL];

  function automatic logic [WIDTH-1:0] shiftStep(
    input logic [WIDTH-1:0] d,
    input logic [1:0]       mode,
    input logic             sign,
    input int               sh
  );
    logic [WIDTH-1:0] r;
    r = '0;
    case (mode)
      MODE_SRL: r = d >> sh;
      MODE_SLL: r = d << sh;
      MODE_SRA: r = (d >> sh) | (sign ? ~({WIDTH{1'b1}} >> sh) : '0);
      MODE_ROL: r = (d << sh) | (d >> (WIDTH - sh));
    endcase
    return r;
  endfunction

  assign adv       = !stVld[LVL-1] || OUT_READY;
  assign IN_READY  = adv;
  assign OUT_VALID = stVld[LVL-1];
  assign OUT_Y     = stData[LVL-1];
  assign OUT_ZERO  = stZero;

  always_comb begin
    inVld[0]  = IN_VALID;
    inData[0] = IN_D;
    inMode[0] = IN_MODE;
    inAmt[0]  = IN_S[LVL-1:0];
    inSign[0] = IN_D[WIDTH-1];
    inOvf[0]  = |IN_S[S_WIDTH-1:LVL];
    for (int k = 1; k < LVL; k++) begin
      inVld[k]  = stVld[k-1];
      inData[k] = stData[k-1];
      inMode[k] = stMode[k-1];
      inAmt[k]  = stAmt[k-1];
      inSign[k] = stSign[k-1];
      inOvf[k]  = stOvf[k-1];
    end
    for (int k = 0; k < LVL; k++) begin
      nxtData[k] = inAmt[k][k] ? shiftStep(inData[k], inMode[k], inSign[k], 1 << k) : inData[k];
    end
    // Oversized amounts saturate in the last stage; rotate just wraps modulo WIDTH.
    if (inOvf[LVL-1] && inMode[LVL-1] != MODE_ROL) begin
      nxtData[LVL-1] = {WIDTH{inMode[LVL-1] == MODE_SRA && inSign[LVL-1]}};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int k = 0; k < LVL; k++) begin
        stVld[k]  <= 1'b0;
        stData[k] <= '0;
        stMode[k] <= '0;
        stAmt[k]  <= '0;
        stSign[k] <= 1'b0;
        stOvf[k]  <= 1'b0;
      end
      stZero <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < LVL; k++) begin
        stVld[k] <= inVld[k];
        if (inVld[k]) begin
          stData[k] <= nxtData[k];
          stMode[k] <= inMode[k];
          stAmt[k]  <= inAmt[k];
          stSign[k] <= inSign[k];
          stOvf[k]  <= inOvf[k];
        end
      end
      if (inVld[LVL-1]) begin
        stZero <= (nxtData[LVL-1] == '0);
      end
    end
  end

endmodule
